// File: rtl/dec_pkg.sv
// Shared helpers for the dec_scan_n decoder family: one-hot generation and
// prescaler counter sizing.
package dec_pkg;

   localparam int unsigned MaxW = 8;
   localparam int unsigned MaxN = 2 ** MaxW;

   // Callers narrow the result to their own N with a width cast.
   function automatic logic [MaxN-1:0] onehot(input int unsigned i);
      logic [MaxN-1:0] v;
      v = '0;
      v[i[MaxW-1:0]] = 1'b1;
      return v;
   endfunction

   function automatic int unsigned cnt_width(input int unsigned div);
      return (div <= 2) ? 1 : $clog2(div);
   endfunction

endpackage

// File: rtl/dec_onehot_n.sv
// Combinational W-to-2^W active-low decoder with a per-output blank mask.
module dec_onehot_n
   import dec_pkg::*;
#(
   parameter int unsigned W = 3
) (
   input  logic [W-1:0]      sel,
   input  logic [2**W-1:0]   blank,
   output logic [2**W-1:0]   y_n
);

   localparam int unsigned N = 2 ** W;

   logic [N-1:0] oh;

   assign oh  = N'(onehot(32'(sel)));
   assign y_n = ~oh | blank;

endmodule

// File: rtl/dec_scan_n.sv
// Registered active-low one-hot select driver with direct and prescaled
// scan modes plus per-output blanking.
module dec_scan_n
   import dec_pkg::*;
#(
   parameter int unsigned W   = 3,
   parameter int unsigned DIV = 100_000
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              mode,
   input  logic [W-1:0]      sel,
   input  logic [W-1:0]      last,
   input  logic [2**W-1:0]   blank,
   output logic [2**W-1:0]   y_n,
   output logic [W-1:0]      idx,
   output logic              tick
);

   localparam int unsigned N  = 2 ** W;
   localparam int unsigned CW = cnt_width(DIV);
   localparam logic [CW-1:0] CntMax = CW'(DIV - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic [W-1:0]  idx_q, idx_d;
   logic [N-1:0]  y_n_q, y_n_d;
   logic          tick_q, tick_d;
   logic [N-1:0]  dec_y_n;

   // Decoding the next index lets y_n, idx and tick change on the same edge.
   dec_onehot_n #(
      .W (W)
   ) u_dec (
      .sel   (idx_d),
      .blank (blank),
      .y_n   (dec_y_n)
   );

   always_comb begin
      cnt_d  = cnt_q;
      idx_d  = idx_q;
      tick_d = 1'b0;
      y_n_d  = '1;
      if (en) begin
         if (!mode) begin
            idx_d = sel;
            cnt_d = '0;
         end else if (cnt_q == CntMax) begin
            cnt_d  = '0;
            tick_d = 1'b1;
            idx_d  = (idx_q >= last) ? '0 : idx_q + W'(1);
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
         y_n_d = dec_y_n;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q  <= '0;
         idx_q  <= '0;
         tick_q <= 1'b0;
         y_n_q  <= '1;
      end else begin
         cnt_q  <= cnt_d;
         idx_q  <= idx_d;
         tick_q <= tick_d;
         y_n_q  <= y_n_d;
      end
   end

   assign y_n  = y_n_q;
   assign idx  = idx_q;
   assign tick = tick_q;

endmodule

// File: tb/tb_dec_scan_n.sv
// Directed bench for dec_scan_n with W = 3, DIV = 4.
module tb_dec_scan_n;

   logic       clk = 1'b0;
   logic       rst_n, en, mode;
   logic [2:0] sel, last;
   logic [7:0] blank;
   logic [7:0] y_n;
   logic [2:0] idx;
   logic       tick;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic       en;
      logic       mode;
      logic [2:0] sel;
      logic [7:0] blank;
      logic [7:0] y;
      logic [2:0] idx;
      logic       tick;
   } vec_t;

   vec_t tbl[13];

   dec_scan_n #(
      .W   (3),
      .DIV (4)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .mode  (mode),
      .sel   (sel),
      .last  (last),
      .blank (blank),
      .y_n   (y_n),
      .idx   (idx),
      .tick  (tick)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      chk("onehot", 32'($countones(~y_n) <= 1), 32'd1);
   endtask

   task automatic expect3(input string name, input logic [7:0] ey, input logic [2:0] ei,
                          input logic et);
      chk({name, ".y_n"}, 32'(y_n), 32'(ey));
      chk({name, ".idx"}, 32'(idx), 32'(ei));
      chk({name, ".tick"}, 32'(tick), 32'(et));
   endtask

   task automatic direct(input logic [2:0] s);
      en = 1'b1; mode = 1'b0; sel = s; blank = 8'h00;
      step();
   endtask

   initial begin
      logic [7:0] ey;
      logic [2:0] ei;

      //           en    mode  sel   blank  y      idx   tick
      tbl[0]  = '{1'b1, 1'b0, 3'd0, 8'h00, 8'hFE, 3'd0, 1'b0};
      tbl[1]  = '{1'b1, 1'b0, 3'd1, 8'h00, 8'hFD, 3'd1, 1'b0};
      tbl[2]  = '{1'b1, 1'b0, 3'd2, 8'h00, 8'hFB, 3'd2, 1'b0};
      tbl[3]  = '{1'b1, 1'b0, 3'd3, 8'h00, 8'hF7, 3'd3, 1'b0};
      tbl[4]  = '{1'b1, 1'b0, 3'd4, 8'h00, 8'hEF, 3'd4, 1'b0};
      tbl[5]  = '{1'b1, 1'b0, 3'd5, 8'h00, 8'hDF, 3'd5, 1'b0};
      tbl[6]  = '{1'b1, 1'b0, 3'd6, 8'h00, 8'hBF, 3'd6, 1'b0};
      tbl[7]  = '{1'b1, 1'b0, 3'd7, 8'h00, 8'h7F, 3'd7, 1'b0};
      tbl[8]  = '{1'b1, 1'b0, 3'd3, 8'h08, 8'hFF, 3'd3, 1'b0};
      tbl[9]  = '{1'b1, 1'b0, 3'd3, 8'hF0, 8'hF7, 3'd3, 1'b0};
      tbl[10] = '{1'b0, 1'b0, 3'd5, 8'h00, 8'hFF, 3'd3, 1'b0};
      tbl[11] = '{1'b1, 1'b0, 3'd5, 8'h00, 8'hDF, 3'd5, 1'b0};
      tbl[12] = '{1'b1, 1'b0, 3'd2, 8'hFF, 8'hFF, 3'd2, 1'b0};

      // Reset held with scan requested
      rst_n = 1'b0; en = 1'b1; mode = 1'b1; sel = 3'd0; last = 3'd7; blank = 8'h00;
      #1;
      for (int i = 0; i < 3; i++) begin
         step();
         expect3("reset", 8'hFF, 3'd0, 1'b0);
      end
      rst_n = 1'b1;
      step();
      expect3("release", 8'hFE, 3'd0, 1'b0);

      // Direct decode table
      for (int i = 0; i < 13; i++) begin
         en = tbl[i].en; mode = tbl[i].mode; sel = tbl[i].sel; blank = tbl[i].blank;
         step();
         expect3($sformatf("vec%0d", i), tbl[i].y, tbl[i].idx, tbl[i].tick);
      end

      // Scan wrap, last = 3
      direct(3'd0);
      mode = 1'b1; last = 3'd3;
      for (int k = 1; k <= 20; k++) begin
         step();
         ei = 3'((k / 4) % 4);
         ey = ~(8'd1 << ei);
         expect3($sformatf("wrap%0d", k), ey, ei, (k % 4) == 0);
      end

      // Last lowered mid-dwell at idx 5
      direct(3'd5);
      mode = 1'b1; last = 3'd7;
      step(); expect3("low1", 8'hDF, 3'd5, 1'b0);
      step(); expect3("low2", 8'hDF, 3'd5, 1'b0);
      last = 3'd2;
      step(); expect3("low3", 8'hDF, 3'd5, 1'b0);
      step(); expect3("low4", 8'hFE, 3'd0, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(); expect3("low5", 8'hFE, 3'd0, 1'b0);
      end
      step(); expect3("low6", 8'hFD, 3'd1, 1'b1);

      // Blank during idx 1, then freeze with en low
      direct(3'd0);
      mode = 1'b1; last = 3'd7; blank = 8'h02;
      for (int k = 0; k < 3; k++) begin
         step(); expect3("blk0", 8'hFE, 3'd0, 1'b0);
      end
      step(); expect3("blk1", 8'hFF, 3'd1, 1'b1);
      step(); expect3("blk2", 8'hFF, 3'd1, 1'b0);
      en = 1'b0; blank = 8'h00;
      for (int k = 0; k < 10; k++) begin
         step(); expect3("hold", 8'hFF, 3'd1, 1'b0);
      end
      en = 1'b1;
      step(); expect3("res1", 8'hFD, 3'd1, 1'b0);
      step(); expect3("res2", 8'hFD, 3'd1, 1'b0);
      step(); expect3("res3", 8'hFB, 3'd2, 1'b1);

      // Direct to scan switch from sel 6
      direct(3'd6);
      expect3("sw0", 8'hBF, 3'd6, 1'b0);
      mode = 1'b1; last = 3'd7;
      for (int k = 0; k < 3; k++) begin
         step(); expect3("sw6", 8'hBF, 3'd6, 1'b0);
      end
      step(); expect3("sw7t", 8'h7F, 3'd7, 1'b1);
      for (int k = 0; k < 3; k++) begin
         step(); expect3("sw7", 8'h7F, 3'd7, 1'b0);
      end
      step(); expect3("sw0t", 8'hFE, 3'd0, 1'b1);

      // Scan back to direct: idx follows sel next edge
      mode = 1'b0; sel = 3'd4;
      step(); expect3("back", 8'hEF, 3'd4, 1'b0);

      // last = 0 pins idx at 0 but still ticks
      direct(3'd0);
      mode = 1'b1; last = 3'd0;
      for (int k = 1; k <= 8; k++) begin
         step(); expect3("pin", 8'hFE, 3'd0, (k % 4) == 0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dec_scan_n.md
# dec_scan_n

Parametrised successor to the fixed 3-to-8 active-low decoder: a W-to-2^W registered one-hot decoder with active-low outputs, a built-in prescaled scan sequencer, and per-output blanking. Drives multiplexed active-low selects (display anodes, bank enables) either from an externally supplied index (direct mode) or from an internal free-running index (scan mode). It sits between the control logic and the board-level select pins.

## Interface

Parameters:
- W, 3, select width; output count N = 2**W (localparam, not overridable)
- DIV, 100_000, prescaler period in clk cycles per scan step; legal range ≥ 1

Ports:
- clk  input  1  system clock, all state on rising edge
- rst_n  input  1  reset, synchronous, active-low
- en  input  1  1 = outputs active; 0 = all outputs deasserted, state frozen
- mode  input  1  0 = direct (decode sel); 1 = scan (decode internal index)
- sel  input  W  index decoded in direct mode
- last  input  W  highest index visited in scan mode; wrap to 0 after it
- blank  input  N  bit i = 1 forces y_n[i] high regardless of index
- y_n  output  N  registered active-low one-hot select
- idx  output  W  registered index currently driven on y_n
- tick  output  1  one-cycle pulse on each scan advance

## Operation

- State: prescaler cnt (width $clog2(DIV), min 1), index idx, registered y_n, registered tick.
- Reset (rst_n = 0 at edge): cnt = 0, idx = 0, tick = 0, y_n = all ones. Reset overrides every other input.
- en = 0: cnt, idx hold; tick = 0; y_n = all ones. Following en rise, decode resumes from the held idx with no reset of cnt.
- Direct mode (en = 1, mode = 0): idx ← sel; cnt ← 0; tick = 0; y_n ← ~(onehot(sel)) | blank.
- Scan mode (en = 1, mode = 1):
  - cnt increments each cycle; at cnt == DIV-1, cnt ← 0 and a step occurs.
  - Step: idx ← (idx ≥ last) ? 0 : idx + 1; tick = 1 for that cycle only.
  - y_n ← ~(onehot(next idx)) | blank, so y_n, idx, tick update on the same edge.
- Mode 0→1: scan continues from the current idx (last sel) with cnt = 0; first step DIV cycles later.
- Mode 1→0: idx follows sel on the next edge; cnt clears.
- last lowered below current idx mid-scan: idx holds until the next step, then wraps to 0 (no out-of-range visit beyond one dwell).
- last = 0: idx pinned at 0; tick still pulses every DIV cycles.
- idx at N-1 with last = N-1: wraps to 0, no overflow.
- blank is applied every cycle, including hold cycles; blank changes are visible on y_n after one edge. All-ones blank → y_n all ones, idx/tick unaffected.
- y_n has at most one bit low in every cycle, never two.

## Timing

- All outputs registered; no combinational input-to-output path.
- Direct mode latency: sel/blank/en change → y_n and idx valid 1 cycle later.
- Scan dwell: exactly DIV cycles per index; tick period DIV cycles; tick high 1 cycle.
- DIV = 1: step every cycle, tick held high while scanning.
- Reset release: first active y_n (idx 0, low bit 0) on the first edge with rst_n = 1 and en = 1.

## Structure

- Package dec_pkg: function onehot #(W) returning N-bit one-hot; shared localparam helper for counter width ($clog2 with minimum 1).
- Sub-module dec_onehot_n: purely combinational W-to-2^W active-low decoder with blank mask (generalisation of the 3-to-8 decoder); dec_scan_n instantiates it on the next-index path and registers its output.
- Sequential logic in one always_ff block; next-state logic in one always_comb block.

## Test plan

- Reset: hold rst_n = 0 for 3 cycles with en = 1, mode = 1 → y_n = 8'hFF, idx = 0, tick = 0; release → y_n = 8'hFE next edge.
- Direct decode (W = 3): sel sweeps 0..7, en = 1, mode = 0, blank = 0 → y_n = 8'hFE, FD, FB, … 7F each one cycle after sel; tick never asserts.
- Scan wrap (DIV = 4, last = 3): idx sequence 0,1,2,3,0 with 4-cycle dwells, tick pulses every 4th cycle, y_n cycles FE, FD, FB, F7.
- Last lowered mid-scan: scanning at idx = 5 (last = 7), set last = 2 → idx stays 5 for rest of dwell, then 0; never visits 6.
- Blank and enable: blank = 8'h02 while scanning → y_n = 8'hFF during idx = 1 dwell; drop en for 10 cycles → y_n = 8'hFF, idx and cnt frozen, dwell resumes with remaining count.
- Mode switch: direct sel = 6 then mode = 1, last = 7 → idx 6 for 4 cycles (DIV = 4), then 7, then 0.
